// File: rtl/rsa_word_loader_pkg.sv
// Shared RSA operand types plus the word-stream geometry used by the input loader.
package rsa_word_loader_pkg;

    localparam int MOD_WIDTH     = 256;
    localparam int WORD_WIDTH    = 32;
    localparam int WORDS_PER_KEY = MOD_WIDTH / WORD_WIDTH;

    typedef logic [MOD_WIDTH-1:0]  KeyType;
    typedef logic [WORD_WIDTH-1:0] WordType;

    typedef struct packed {
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAModIn;

endpackage

// File: rtl/rsa_word_loader.sv
// Deserializes a framed 32-bit word stream into one {msg, key, modulus} packet for the RSA core.
// Malformed frames (early or missing last) are dropped with a one-cycle error pulse.
module rsa_word_loader #(
    parameter int MOD_WIDTH  = 256,
    parameter int WORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [WORD_WIDTH-1:0]         i_word,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          o_ready,
    output rsa_word_loader_pkg::RSAModIn  o_out,
    output logic                          o_err
);
    import rsa_word_loader_pkg::*;

    localparam int N  = MOD_WIDTH / WORD_WIDTH;
    localparam int F  = 3 * N;
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        ERR
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [1:0]           op_q, op_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [MOD_WIDTH-1:0] msg_q, key_q, mod_q;
    logic                 wr_en;
    logic                 accept;
    logic                 at_final;

    assign accept   = i_valid && (state_q == COLLECT);
    assign at_final = (count_q == CW'(F - 1));

    // i_ready depends only on state, so o_ready never reaches it combinationally.
    assign i_ready = (state_q == COLLECT);
    assign o_valid = (state_q == HOLD);
    assign o_err   = (state_q == ERR);

    always_comb begin
        o_out.msg     = msg_q;
        o_out.key     = key_q;
        o_out.modulus = mod_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (at_final && i_last) begin
                        wr_en   = 1'b1;
                        state_d = HOLD;
                        count_d = '0;
                        op_d    = '0;
                        slot_d  = '0;
                    end else if (!at_final && !i_last) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        if (slot_q == SW'(N - 1)) begin
                            slot_d = '0;
                            op_d   = op_q + 2'd1;
                        end else begin
                            slot_d = slot_q + SW'(1);
                        end
                    end else begin
                        // Framing violation: the offending word is discarded.
                        state_d = ERR;
                        count_d = '0;
                        op_d    = '0;
                        slot_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (o_ready) state_d = COLLECT;
            end
            ERR: begin
                state_d = COLLECT;
                count_d = '0;
                op_d    = '0;
                slot_d  = '0;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            count_q <= '0;
            op_q    <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            slot_q  <= slot_d;
        end
    end

    // Operands are only cleared by reset; a dropped frame leaves stale words that the next frame overwrites.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_q <= '0;
            key_q <= '0;
            mod_q <= '0;
        end else if (wr_en) begin
            case (op_q)
                2'd0:    msg_q[int'(slot_q) * WORD_WIDTH +: WORD_WIDTH] <= i_word;
                2'd1:    key_q[int'(slot_q) * WORD_WIDTH +: WORD_WIDTH] <= i_word;
                default: mod_q[int'(slot_q) * WORD_WIDTH +: WORD_WIDTH] <= i_word;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_word_loader.sv
// Self-checking bench for rsa_word_loader: table of frame scenarios plus reset corner sequences.
module tb_rsa_word_loader;
    import rsa_word_loader_pkg::*;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int F  = 24;
    localparam int PW = 768;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  i_word;
    logic          i_last;
    logic          o_valid;
    logic          o_ready;
    RSAModIn       o_out;
    logic          o_err;

    always #5 clk = ~clk;

    rsa_word_loader #(.MOD_WIDTH(256), .WORD_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_word  (i_word),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_out   (o_out),
        .o_err   (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit spurious;

    // mode: 0 = incrementing from base, 1 = constant base, 2 = random words
    typedef struct {
        string       name;
        int          mode;
        logic [31:0] base;
        int          len;
        int          last_at;
        bit          bubbles;
        int          hold_cycles;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] words[F];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: word k of the frame lands in operand k/N at slot k%N.
    function automatic RSAModIn model_pkt();
        RSAModIn p;
        p = '0;
        for (int k = 0; k < F; k++) begin
            case (k / N)
                0:       p.msg[32*(k%N) +: 32]     = words[k];
                1:       p.key[32*(k%N) +: 32]     = words[k];
                default: p.modulus[32*(k%N) +: 32] = words[k];
            endcase
        end
        return p;
    endfunction

    // Called at a negedge; returns at the negedge right after the word is taken.
    task automatic send_word(input logic [31:0] w, input bit l, input bit bubbles);
        bit acc;
        if (bubbles) begin
            repeat ($urandom_range(2, 0)) begin
                i_valid = 1'b0;
                i_word  = $urandom;
                i_last  = 1'($urandom);
                if (o_valid || o_err) spurious = 1'b1;
                @(negedge clk);
            end
        end
        i_valid = 1'b1;
        i_word  = w;
        i_last  = l;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            acc = i_ready;
            if (o_valid || o_err) spurious = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no i_ready expected acceptance within 100 cycles");
        end
    endtask

    task automatic run_vec(input vec_t v);
        RSAModIn exp;
        for (int k = 0; k < F; k++) begin
            case (v.mode)
                0:       words[k] = v.base + 32'(k);
                1:       words[k] = v.base;
                default: words[k] = $urandom;
            endcase
        end
        o_ready  = (v.hold_cycles == 0);
        spurious = 1'b0;
        for (int k = 0; k < v.len; k++) send_word(words[k], (k + 1 == v.last_at), v.bubbles);
        chk({v.name, ".no_early_output"}, PW'(spurious), PW'(0));
        if (v.exp_err) begin
            chk({v.name, ".err_pulse"}, PW'({o_err, o_valid, i_ready}), PW'(3'b100));
            @(negedge clk);
            chk({v.name, ".err_done"}, PW'({o_err, o_valid, i_ready}), PW'(3'b001));
        end else begin
            exp = model_pkt();
            chk({v.name, ".valid_flags"}, PW'({o_err, o_valid, i_ready}), PW'(3'b010));
            chk({v.name, ".packet"}, PW'(o_out), PW'(exp));
            repeat (v.hold_cycles) begin
                @(negedge clk);
                chk({v.name, ".held"}, PW'({o_valid, i_ready, o_out}), PW'({1'b1, 1'b0, exp}));
            end
            o_ready = 1'b1;
            @(negedge clk);
            chk({v.name, ".after_hs"}, PW'({o_err, o_valid, i_ready}), PW'(3'b001));
        end
    endtask

    initial begin
        tbl[0]  = '{"basic",        0, 32'h1,        24, 24, 1'b0, 0,  1'b0};
        tbl[1]  = '{"backpressure", 2, 32'h0,        24, 24, 1'b0, 10, 1'b0};
        tbl[2]  = '{"early_last",   0, 32'h100,      5,  5,  1'b0, 0,  1'b1};
        tbl[3]  = '{"all_a5",       1, 32'hA5A5A5A5, 24, 24, 1'b0, 0,  1'b0};
        tbl[4]  = '{"missing_last", 2, 32'h0,        24, 0,  1'b0, 0,  1'b1};
        tbl[5]  = '{"after_miss",   2, 32'h0,        24, 24, 1'b0, 3,  1'b0};
        tbl[6]  = '{"bubbly",       2, 32'h0,        24, 24, 1'b1, 0,  1'b0};
        tbl[7]  = '{"bubbly_bp",    2, 32'h0,        24, 24, 1'b1, 2,  1'b0};
        tbl[8]  = '{"last_first",   2, 32'h0,        1,  1,  1'b0, 0,  1'b1};
        tbl[9]  = '{"last_at_23",   2, 32'h0,        23, 23, 1'b1, 0,  1'b1};
        tbl[10] = '{"incr_high",    0, 32'hF0000000, 24, 24, 1'b0, 1,  1'b0};
        tbl[11] = '{"random",       2, 32'h0,        24, 24, 1'b0, 0,  1'b0};

        rst     = 1'b0;
        i_valid = 1'b0;
        i_word  = '0;
        i_last  = 1'b0;
        o_ready = 1'b0;
        #1;
        chk("reset_state", PW'({o_valid, o_err, i_ready, o_out}), PW'({1'b0, 1'b0, 1'b1, 768'h0}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // Reset in the middle of a frame: partial frame lost, no error raised.
        o_ready = 1'b1;
        spurious = 1'b0;
        for (int k = 0; k < 12; k++) send_word(32'hC0DE0000 + 32'(k), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_mid_frame", PW'({o_valid, o_err, i_ready, o_out}), PW'({1'b0, 1'b0, 1'b1, 768'h0}));
        @(negedge clk);
        chk("rst_mid_no_err", PW'(o_err), PW'(0));
        rst = 1'b1;
        run_vec(tbl[11]);

        // Reset while a packet is being held.
        o_ready = 1'b0;
        for (int k = 0; k < F; k++) send_word($urandom, (k == F - 1), 1'b0);
        chk("hold_before_rst", PW'(o_valid), PW'(1));
        rst = 1'b0;
        #1;
        chk("rst_in_hold", PW'({o_valid, o_err, i_ready, o_out}), PW'({1'b0, 1'b0, 1'b1, 768'h0}));
        @(negedge clk);
        rst = 1'b1;
        run_vec(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
